// File: rtl/spi_peripheral.sv
// SPI mode-0, write-only target holding the PWM configuration register bank.
// Raw SPI pins are synchronised into the clk domain. A 16-bit frame
// (R/W, 7-bit address, 8-bit data, MSB first) is committed when nCS rises,
// but only if the frame is a complete, valid write.
module spi_peripheral #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk_in,
  input  logic       copi_in,
  input  logic       ncs_in,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [4:0] CNT_FULL = 5'd16;
  localparam logic [4:0] CNT_OVR  = 5'd17;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] copi_sync_q;
  logic [SYNC_STAGES-1:0] ncs_sync_q;
  logic                   sclk_hist_q;
  logic                   ncs_hist_q;

  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, ncs_fall, ncs_rise;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] shift_q, shift_d;
  logic        fall_pend_q, fall_pend_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [7:0]  reg0_q, reg0_d;
  logic [7:0]  reg1_q, reg1_d;
  logic [7:0]  reg2_q, reg2_d;
  logic [7:0]  reg3_q, reg3_d;
  logic [7:0]  reg4_q, reg4_d;

  logic [6:0] frame_addr;
  logic [7:0] frame_data;
  logic       frame_ok;

  // Synchronisers plus one history flop for SCLK/nCS edge detection.
  // nCS resets high so an idle bus looks deselected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_hist_q <= 1'b0;
      ncs_hist_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi_in};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs_in};
      sclk_hist_q <= sclk_sync_q[SYNC_STAGES-1];
      ncs_hist_q  <= ncs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign ncs_fall  = ~ncs_s & ncs_hist_q;
  assign ncs_rise  = ncs_s & ~ncs_hist_q;

  assign frame_addr = shift_q[14:8];
  assign frame_data = shift_q[7:0];
  assign frame_ok   = (cnt_q == CNT_FULL) && shift_q[15] && (frame_addr <= MAX_ADDR);

  // State, frame capture and register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      fall_pend_q <= 1'b0;
      wr_strobe_q <= 1'b0;
      reg0_q      <= '0;
      reg1_q      <= '0;
      reg2_q      <= '0;
      reg3_q      <= '0;
      reg4_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      fall_pend_q <= fall_pend_d;
      wr_strobe_q <= wr_strobe_d;
      reg0_q      <= reg0_d;
      reg1_q      <= reg1_d;
      reg2_q      <= reg2_d;
      reg3_q      <= reg3_d;
      reg4_q      <= reg4_d;
    end
  end

  // Next-state logic: shift during SHIFT, decide the write in COMMIT.
  // A nCS fall seen during COMMIT is remembered for the next IDLE cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    fall_pend_d = 1'b0;
    wr_strobe_d = 1'b0;
    reg0_d      = reg0_q;
    reg1_d      = reg1_q;
    reg2_d      = reg2_q;
    reg3_d      = reg3_q;
    reg4_d      = reg4_q;
    case (state_q)
      IDLE: begin
        if (ncs_fall || fall_pend_q) begin
          cnt_d   = '0;
          shift_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (sclk_rise) begin
          shift_d = {shift_q[14:0], copi_s};
          if (cnt_q != CNT_OVR) cnt_d = cnt_q + 5'd1;
        end
        if (ncs_rise) state_d = COMMIT;
      end
      COMMIT: begin
        if (frame_ok) begin
          wr_strobe_d = 1'b1;
          case (frame_addr)
            7'h00:   reg0_d = frame_data;
            7'h01:   reg1_d = frame_data;
            7'h02:   reg2_d = frame_data;
            7'h03:   reg3_d = frame_data;
            7'h04:   reg4_d = frame_data;
            default: wr_strobe_d = 1'b1;
          endcase
        end
        fall_pend_d = ncs_fall;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign en_reg_out_7_0  = reg0_q;
  assign en_reg_out_15_8 = reg1_q;
  assign en_reg_pwm_7_0  = reg2_q;
  assign en_reg_pwm_15_8 = reg3_q;
  assign pwm_duty_cycle  = reg4_q;
  assign wr_strobe       = wr_strobe_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Scoreboard bench for spi_peripheral: the SPI driver pushes expected writes,
// a monitor pops them on every wr_strobe pulse and checks the written register.
module tb_spi_peripheral;

  logic       clk;
  logic       rst_n;
  logic       sclk_in, copi_in, ncs_in;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_strobe;

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;
  int exp_cnt    = 0;

  logic [7:0]  model [5];
  logic [15:0] exp_q [$];

  spi_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(7'h04)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sclk_in        (sclk_in),
    .copi_in        (copi_in),
    .ncs_in         (ncs_in),
    .en_reg_out_7_0 (en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0 (en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle (pwm_duty_cycle),
    .wr_strobe      (wr_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] reg_at(input int a);
    case (a)
      0:       return en_reg_out_7_0;
      1:       return en_reg_out_15_8;
      2:       return en_reg_pwm_7_0;
      3:       return en_reg_pwm_15_8;
      default: return pwm_duty_cycle;
    endcase
  endfunction

  task automatic check_bank(input string tag);
    chk({tag, " en_out_7_0"},  {24'd0, en_reg_out_7_0},  {24'd0, model[0]});
    chk({tag, " en_out_15_8"}, {24'd0, en_reg_out_15_8}, {24'd0, model[1]});
    chk({tag, " en_pwm_7_0"},  {24'd0, en_reg_pwm_7_0},  {24'd0, model[2]});
    chk({tag, " en_pwm_15_8"}, {24'd0, en_reg_pwm_15_8}, {24'd0, model[3]});
    chk({tag, " duty"},        {24'd0, pwm_duty_cycle},  {24'd0, model[4]});
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_low(input int ph);
    ncs_in = 1'b0;
    wclk(ph);
  endtask

  task automatic send_bit(input logic b, input int ph);
    copi_in = b;
    wclk(ph);
    sclk_in = 1'b1;
    wclk(ph);
    sclk_in = 1'b0;
  endtask

  // Drive one frame of n bits (LSB-aligned in bits), then deselect for gap clks.
  // With lat set, the nCS-rise to write latency is checked cycle by cycle.
  task automatic frame(input logic [31:0] bits, input int n, input int ph,
                       input int gap, input bit lat);
    logic [15:0] f;
    logic [7:0]  old_v;
    int          a;
    bit          ok;
    f  = bits[15:0];
    a  = int'(f[14:8]);
    ok = (n == 16) && f[15] && (f[14:8] <= 7'h04);
    cs_low(ph);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i], ph);
    wclk(ph);
    old_v = ok ? model[a] : 8'h00;
    if (ok) begin
      model[a] = f[7:0];
      exp_q.push_back(f);
      exp_cnt++;
    end
    @(posedge clk);
    #1 ncs_in = 1'b1;
    for (int k = 1; k <= gap; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (lat && ok) begin
        chk($sformatf("latency strobe k=%0d", k), {31'd0, wr_strobe}, {31'd0, (k == 4)});
        chk($sformatf("latency reg k=%0d", k), {24'd0, reg_at(a)},
            {24'd0, (k >= 4) ? f[7:0] : old_v});
      end
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && wr_strobe) begin
      logic [15:0] e;
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected wr_strobe", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("write addr %0d", e[14:8]), {24'd0, reg_at(int'(e[14:8]))}, {24'd0, e[7:0]});
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    rst_n   = 1'b0;
    sclk_in = 1'b0;
    copi_in = 1'b0;
    ncs_in  = 1'b1;
    wclk(3);
    chk("reset wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check_bank("reset");
    rst_n = 1'b1;
    wclk(20);
    check_bank("idle");

    // Single write with latency check
    frame(32'h8055, 16, 5, 8, 1'b1);
    check_bank("single");

    // Five back-to-back writes, minimal deselect gap
    frame(32'h80F0, 16, 4, 4, 1'b0);
    frame(32'h81CC, 16, 4, 4, 1'b0);
    frame(32'h820F, 16, 4, 4, 1'b0);
    frame(32'h8333, 16, 4, 4, 1'b0);
    frame(32'h8480, 16, 4, 4, 1'b0);
    wclk(8);
    check_bank("b2b");

    // Discarded frames against the preloaded bank
    frame(32'h0480, 16, 3, 6, 1'b0);
    frame(32'h0411, 16, 3, 6, 1'b0);
    frame(32'h0422, 15, 3, 6, 1'b0);
    frame(32'h08411, 17, 3, 6, 1'b0);
    frame(32'h85AA, 16, 3, 6, 1'b0);
    wclk(6);
    check_bank("discard");

    // Reset in the middle of a frame
    frame(32'h8440, 16, 4, 6, 1'b0);
    check_bank("pre-reset");
    cs_low(4);
    for (int i = 15; i >= 8; i--) begin
      logic [15:0] v;
      v = 16'h84FF;
      send_bit(v[i], 4);
    end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) model[i] = 8'h00;
    check_bank("async reset");
    wclk(3);
    rst_n = 1'b1;
    wclk(2);
    for (int i = 7; i >= 0; i--) send_bit(1'b1, 4);
    wclk(4);
    ncs_in = 1'b1;
    wclk(8);
    check_bank("after partial");
    frame(32'h8420, 16, 4, 6, 1'b0);
    chk("duty after reset", {24'd0, pwm_duty_cycle}, 32'h20);

    // Random valid frames over the allowed SCLK phase range
    for (int r = 0; r < 12; r++) begin
      logic [15:0] f;
      f = {1'b1, 7'($urandom_range(0, 4)), 8'($urandom_range(0, 255))};
      frame({16'd0, f}, 16, int'($urandom_range(3, 20)), 5, 1'b0);
    end
    wclk(8);
    check_bank("random");

    chk("strobe count", strobe_cnt, exp_cnt);
    chk("scoreboard drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
- SPI target (mode 0, write-only) that holds the PWM peripheral's configuration register bank.
- Sits directly upstream of the PWM stage. Inputs come from the dedicated input pins: ui_in[0] = SCLK, ui_in[1] = COPI, ui_in[2] = nCS.
- Outputs drive the PWM stage's en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle inputs directly.
- SPI pins are asynchronous to clk. They are synchronised internally, and registers update only on a complete, valid 16-bit frame.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser (minimum 2).
- MAX_ADDR, 7'h04, highest writable register address; frames to higher addresses are discarded.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sclk_in  input  1  raw SPI clock (ui_in[0])
- copi_in  input  1  raw SPI data, controller to peripheral (ui_in[1])
- ncs_in  input  1  raw SPI chip select, active low (ui_in[2])
- en_reg_out_7_0  output  8  register 0x00, output enables, pins 7..0
- en_reg_out_15_8  output  8  register 0x01, output enables, pins 15..8
- en_reg_pwm_7_0  output  8  register 0x02, PWM enables, pins 7..0
- en_reg_pwm_15_8  output  8  register 0x03, PWM enables, pins 15..8
- pwm_duty_cycle  output  8  register 0x04, duty (0x00 = 0 %, 0xFF = 100 %)
- wr_strobe  output  1  one-clk pulse on the cycle a register is written

Behaviour:
- Clock and reset are decided: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset (rst_n = 0, asynchronous):
  - All five registers = 0x00; wr_strobe = 0; FSM = IDLE; bit counter = 0; shift register = 0.
  - Synchroniser flops reset to SCLK 0, COPI 0, nCS 1.
- Synchronisation:
  - Each raw input passes through SYNC_STAGES flops.
  - One extra history flop per SCLK and nCS gives edge detection on the synchronised signals.
  - COPI uses the same depth, so it stays aligned with SCLK.
- Frame format: 16 bits, MSB first, sampled on SCLK rising edge.
  - bit15 = R/W (1 = write).
  - bits14:8 = address.
  - bits7:0 = data.
- FSM states:
  - IDLE: on nCS falling edge, clear counter and shift register, go to SHIFT.
  - SHIFT: on each SCLK rising edge, shift the synchronised COPI into the LSB. The counter increments and saturates at 17; 17 means overrun. On nCS rising edge, go to COMMIT.
  - COMMIT (one cycle): write only if counter == 16, bit15 == 1 and address <= MAX_ADDR. Load data into the addressed register, assert wr_strobe for this cycle only, then return to IDLE.
- Discarded frames leave all registers and wr_strobe unchanged:
  - fewer than 16 bits;
  - more than 16 bits;
  - bit15 = 0 (reads are not supported, and COPI-only operation produces no reply);
  - address > MAX_ADDR.
- SCLK edges while in IDLE or COMMIT are ignored.
- nCS falling during COMMIT is detected on the following IDLE cycle (edge flag held one cycle), so back-to-back frames are not lost.
- Latency, SYNC_STAGES = 2: the raw nCS rise is first sampled at clk edge N. The register and wr_strobe update at edge N+3; wr_strobe deasserts at N+4.
- Timing requirement on the controller:
  - SCLK high and low phases ≥ 3 clk periods each.
  - nCS setup to first SCLK rise ≥ 3 clk periods; last SCLK fall to nCS rise ≥ 3 clk periods.
  - nCS high between frames ≥ 4 clk periods.
- Reset mid-frame aborts the frame with no register change.
- If nCS is low when reset releases, a falling edge is detected (sync resets to 1). The partial frame that follows is then counted and discarded unless it happens to be exactly 16 bits.
- Registers hold their values indefinitely; there is no readback and no clearing except reset.

Test Plan:
- Reset, then no SPI activity -> all five registers 0x00, wr_strobe never asserted.
- Write frame 0x8055 (W, addr 0x00, data 0x55), SCLK phase = 5 clk -> en_reg_out_7_0 = 0x55 at nCS-rise +3 clk, one wr_strobe pulse, other registers 0x00.
- Five back-to-back writes with addr 0x00..0x04, data 0xF0, 0xCC, 0x0F, 0x33, 0x80, nCS high 4 clk between frames -> all five registers hold those values, exactly five wr_strobe pulses.
- Discard cases, each against a preloaded bank (duty = 0x80):
  - read frame 0x0480;
  - 15-bit frame;
  - 17-bit frame;
  - address 0x05 frame 0x85AA;
  - → no register change and no wr_strobe in any case.
- Assert rst_n low after bit 8 of frame 0x84FF with duty previously 0x40 -> duty = 0x00 immediately, state IDLE. Next valid frame 0x8420 sets duty = 0x20.
- Randomised valid frames with SCLK phases 3..20 clk, checked against a reference register model -> full match, wr_strobe count equals the number of valid frames.
